// File: rtl/rgmii_rx_dly_cal.sv
// RGMII RX input-delay calibration controller.
// Sweeps the shared IODELAY tap (all five lanes together), scores each tap
// against the received preamble, then parks at the centre of the widest
// passing window.
module rgmii_rx_dly_cal #(
   parameter int STATIC_DLY     = 63,
   parameter int MAX_TAP        = 127,
   parameter int FRAMES_PER_TAP = 4,
   parameter int PRE_SAMPLES    = 6,
   parameter int SETTLE         = 8,
   parameter int TIMEOUT        = 1 << 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [9:0] q_in,
   input  logic       df,
   output logic       sdtap,
   output logic       value,
   output logic       setn,
   output logic [6:0] cur_tap,
   output logic [6:0] win_lo,
   output logic [6:0] win_hi,
   output logic       busy,
   output logic       locked,
   output logic       cal_fail
);
   localparam logic [9:0] PRE_PAT    = 10'h2B5;
   localparam int         CW         = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
   localparam int         TW         = $clog2(TIMEOUT + 1);
   localparam int         FW         = $clog2(FRAMES_PER_TAP + 1);
   localparam int         SW         = $clog2(PRE_SAMPLES + 1);
   localparam logic [6:0] STATIC_TAP = 7'(STATIC_DLY);
   localparam logic [6:0] MAX_T      = 7'(MAX_TAP);

   typedef enum logic [2:0] {IDLE, LOAD, RWND, MEAS, NEXT, SEEK, DONE, FAIL} state_t;
   state_t state, state_n;

   logic [CW-1:0] cnt;        // settle countdown after any delay change
   logic [TW-1:0] tmo;        // cycles since last frame start in this tap
   logic [FW-1:0] frames;     // frames fully scored at this tap
   logic [SW-1:0] win_cnt;    // samples still to score in the current frame
   logic          err;        // tap-error flag
   logic          ctl_q, df_q, df_seen;
   logic [6:0]    run_lo;
   logic [7:0]    run_len, best_len;
   logic          ld, step, dir, step_ok;

   // Scoring datapath: frame start is a rising edge of CTL (both halves);
   // a start inside an active scoring window is just more of the same frame.
   logic       ctl_hi, in_win, new_frame, settling, scoring, last_smp;
   logic       smp_err, frame_done, tap_done, tap_pass;
   logic [7:0] tap_sum;
   logic [6:0] target;

   assign ctl_hi     = q_in[4] & q_in[9];
   assign in_win     = (win_cnt != '0);
   assign new_frame  = ctl_hi & ~ctl_q & ~in_win;
   assign settling   = (cnt != '0);
   assign scoring    = (state == MEAS) && !settling && (in_win || new_frame);
   assign last_smp   = in_win ? (win_cnt == SW'(1)) : (PRE_SAMPLES == 1);
   assign smp_err    = (q_in != PRE_PAT);
   assign frame_done = scoring && last_smp;
   assign tap_done   = frame_done && (frames == FW'(FRAMES_PER_TAP - 1));
   assign tap_pass   = !(err || smp_err);
   assign tap_sum    = {1'b0, win_lo} + {1'b0, win_hi};
   assign target     = tap_sum[7:1];
   assign step_ok    = step && (dir ? (cur_tap != '0) : (cur_tap != MAX_T));

   assign busy     = !(state == IDLE || state == DONE || state == FAIL);
   assign locked   = (state == DONE);
   assign cal_fail = (state == FAIL);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Next-state and step requests; IDLE always launches a calibration so
   // reset release behaves like a start pulse.
   always_comb begin
      state_n = state;
      ld      = 1'b0;
      step    = 1'b0;
      dir     = 1'b0;
      case (state)
         IDLE: begin state_n = LOAD; ld = 1'b1; end
         LOAD: if (!settling) state_n = RWND;
         RWND: if (!settling) begin
                  if (cur_tap != '0) begin step = 1'b1; dir = 1'b1; end
                  else state_n = MEAS;
               end
         MEAS: if (!settling) begin
                  if (tap_done) state_n = NEXT;
                  else if (!new_frame && tmo == TW'(TIMEOUT - 1)) state_n = FAIL;
               end
         NEXT: if (cur_tap == MAX_T || df_seen) state_n = SEEK;
               else begin step = 1'b1; state_n = MEAS; end
         SEEK: if (best_len == '0) state_n = FAIL;
               else if (!settling) begin
                  if (cur_tap != target) begin step = 1'b1; dir = 1'b1; end
                  else state_n = DONE;
               end
         DONE, FAIL: if (start) begin state_n = LOAD; ld = 1'b1; end
         default: state_n = IDLE;
      endcase
   end

   // Delay controls, tap tracking, per-tap scoring and window bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sdtap    <= 1'b0;
         value    <= 1'b0;
         setn     <= 1'b0;
         cur_tap  <= STATIC_TAP;
         win_lo   <= '0;
         win_hi   <= '0;
         cnt      <= '0;
         tmo      <= '0;
         frames   <= '0;
         win_cnt  <= '0;
         err      <= 1'b0;
         ctl_q    <= 1'b0;
         df_q     <= 1'b0;
         df_seen  <= 1'b0;
         run_lo   <= '0;
         run_len  <= '0;
         best_len <= '0;
      end else begin
         sdtap <= ld;
         value <= 1'b0;
         ctl_q <= ctl_hi;
         df_q  <= df;
         if (state == MEAS && df && !df_q) df_seen <= 1'b1;

         if (ld) begin
            cur_tap  <= STATIC_TAP;
            cnt      <= CW'(SETTLE);
            win_lo   <= '0;
            win_hi   <= '0;
            run_lo   <= '0;
            run_len  <= '0;
            best_len <= '0;
            df_seen  <= 1'b0;
         end else if (step_ok) begin
            value   <= 1'b1;
            setn    <= dir;
            cur_tap <= dir ? cur_tap - 7'd1 : cur_tap + 7'd1;
            cnt     <= CW'(SETTLE);
         end else if (settling) begin
            cnt <= cnt - CW'(1);
         end

         if (state != MEAS || settling || tap_done) begin
            tmo     <= '0;
            win_cnt <= '0;
            frames  <= '0;
            err     <= 1'b0;
         end else begin
            tmo <= new_frame ? '0 : tmo + TW'(1);
            if (scoring) begin
               err     <= err | smp_err;
               win_cnt <= in_win ? win_cnt - SW'(1) : SW'(PRE_SAMPLES - 1);
               if (frame_done) frames <= frames + FW'(1);
            end
         end

         // Strictly-longer replacement keeps the earliest of equal windows.
         if (tap_done) begin
            if (tap_pass) begin
               run_len <= run_len + 8'd1;
               if (run_len == '0) run_lo <= cur_tap;
               if ((run_len + 8'd1) > best_len) begin
                  best_len <= run_len + 8'd1;
                  win_lo   <= (run_len == '0) ? cur_tap : run_lo;
                  win_hi   <= cur_tap;
               end
            end else begin
               run_len <= '0;
            end
         end
      end
   end
endmodule

// File: tb/tb_rgmii_rx_dly_cal.sv
// Bench for rgmii_rx_dly_cal: an IODELAY + PHY model driven by the DUT's
// delay controls, with randomized frames whose preamble is clean only at
// the taps marked good. Final results come from a window-search model.
module tb_rgmii_rx_dly_cal;
   localparam int STATIC_DLY = 63;
   localparam int MAX_TAP    = 127;
   localparam int FRAMES     = 2;
   localparam int PRE        = 6;
   localparam int SETTLE     = 3;
   localparam int TIMEOUT    = 600;
   localparam logic [9:0] PRE_PAT = 10'h2B5;

   logic       clk = 1'b0, rst = 1'b0, start = 1'b0, df = 1'b0;
   logic [9:0] q_in = '0;
   logic       sdtap, value, setn, busy, locked, cal_fail;
   logic [6:0] cur_tap, win_lo, win_hi;

   rgmii_rx_dly_cal #(
      .STATIC_DLY(STATIC_DLY), .MAX_TAP(MAX_TAP), .FRAMES_PER_TAP(FRAMES),
      .PRE_SAMPLES(PRE), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .q_in(q_in), .df(df),
      .sdtap(sdtap), .value(value), .setn(setn), .cur_tap(cur_tap),
      .win_lo(win_lo), .win_hi(win_hi), .busy(busy), .locked(locked),
      .cal_fail(cal_fail)
   );

   always #5 clk = ~clk;

   int           vec = 0, errs = 0;
   logic [127:0] good_map = '0;
   bit           df_force = 1'b0, frames_en = 1'b1;
   int           phys = 0, phase = 0;
   bit           synced = 1'b0;
   int           n_rw = 0, n_up = 0, n_sk = 0, n_sd = 0;
   longint       cyc = 0, last_evt = 0, last_step = 0;
   logic         prev_value = 1'b0, prev_setn = 1'b0;
   int           gap_left = 3, fr_pos = 0, fr_len = 0, err_pos = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      vec++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [127:0] rng(input int a, input int b);
      logic [127:0] m = '0;
      for (int i = a; i <= b; i++) m[i] = 1'b1;
      return m;
   endfunction

   // Earliest longest run of good taps in 0..end_tap.
   function automatic void model(input logic [127:0] m, input int end_tap,
                                 output bit ok, output int lo, output int hi);
      int best = 0;
      lo = 0; hi = 0;
      for (int s = 0; s <= end_tap; s++) begin
         if (m[s] && (s == 0 || !m[s-1])) begin
            int e = s;
            while (e < end_tap && m[e+1]) e++;
            if (e - s + 1 > best) begin best = e - s + 1; lo = s; hi = e; end
         end
      end
      ok = (best > 0);
   endfunction

   // Per-cycle monitor (IODELAY model + control-protocol checks) and PHY driver.
   initial forever begin
      int r;
      @(negedge clk);
      cyc++;
      if (rst) synced = 1'b0;
      else begin
         if (sdtap) begin
            phys = STATIC_DLY; synced = 1'b1; phase = 0;
            n_rw = 0; n_up = 0; n_sk = 0; n_sd++; last_evt = cyc;
         end
         if (value) begin
            chk("step_gap", longint'(cyc - last_evt >= SETTLE + 1), 1);
            chk("value_width", prev_value, 0);
            if (setn) begin
               if (phys > 0) phys--;
               if (phase == 1) phase = 2;
               if (phase == 0) n_rw++; else n_sk++;
            end else begin
               if (phys < MAX_TAP) phys++;
               chk("step_dir", longint'(phase == 2), 0);
               phase = 1; n_up++;
            end
            last_evt = cyc; last_step = cyc;
         end
         if (setn != prev_setn) chk("setn_with_value", value, 1);
         if (synced) chk("cur_tap", cur_tap, phys);
         chk("state_excl", longint'((busy && locked) || (busy && cal_fail) || (locked && cal_fail)), 0);
      end
      prev_value = value; prev_setn = setn;

      df = df_force && (phys >= 100);
      if (!frames_en) begin
         q_in = 10'($urandom) & ~10'h010; gap_left = 2;
      end else if (gap_left > 0) begin
         q_in = 10'($urandom) & ~10'h010; gap_left--;
         if (gap_left == 0) begin
            fr_pos = 0; fr_len = PRE + int'($urandom_range(0, 3));
            err_pos = int'($urandom_range(0, PRE - 1));
         end
      end else begin
         if (fr_pos < PRE) begin
            q_in = PRE_PAT;
            if (!good_map[phys] && (fr_pos == err_pos || $urandom_range(0, 3) == 0)) begin
               r = int'($urandom_range(0, 7));
               q_in[(r < 4) ? r : r + 1] = ~q_in[(r < 4) ? r : r + 1];
            end
         end else begin
            q_in = 10'($urandom) | 10'h210;
         end
         fr_pos++;
         if (fr_pos >= fr_len) gap_left = int'($urandom_range(2, 5));
      end
   end

   task automatic chk_reset(input string tag);
      chk({tag, "_sdtap"}, sdtap, 0);     chk({tag, "_value"}, value, 0);
      chk({tag, "_setn"}, setn, 0);       chk({tag, "_cur_tap"}, cur_tap, STATIC_DLY);
      chk({tag, "_win_lo"}, win_lo, 0);   chk({tag, "_win_hi"}, win_hi, 0);
      chk({tag, "_busy"}, busy, 0);       chk({tag, "_locked"}, locked, 0);
      chk({tag, "_cal_fail"}, cal_fail, 0);
   endtask

   task automatic pulse_start;
      @(negedge clk); #1 start = 1'b1;
      @(negedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_cal(input string name, input bit lit, input bit l_ok,
                           input int l_lo, input int l_hi, input int l_tap);
      int end_tap, lo, hi, exp_tap, n;
      bit ok;
      end_tap = df_force ? 100 : MAX_TAP;
      model(good_map, end_tap, ok, lo, hi);
      exp_tap = ok ? (lo + hi) / 2 : end_tap;
      n = 0;
      while (!busy && n < 20) begin @(negedge clk); n++; end
      chk({name, "_busy"}, busy, 1);
      n = 0;
      while (busy && n < 30000) begin @(negedge clk); n++; end
      chk({name, "_finished"}, busy, 0);
      chk({name, "_locked"}, locked, ok);
      chk({name, "_cal_fail"}, cal_fail, !ok);
      chk({name, "_win_lo"}, win_lo, lo);
      chk({name, "_win_hi"}, win_hi, hi);
      chk({name, "_cur_tap"}, cur_tap, exp_tap);
      chk({name, "_rewind_steps"}, n_rw, STATIC_DLY);
      chk({name, "_up_steps"}, n_up, end_tap);
      chk({name, "_seek_steps"}, n_sk, ok ? end_tap - exp_tap : 0);
      if (lit) begin
         chk({name, "_lit_locked"}, locked, l_ok);
         chk({name, "_lit_lo"}, win_lo, l_lo);
         chk({name, "_lit_hi"}, win_hi, l_hi);
         chk({name, "_lit_tap"}, cur_tap, l_tap);
      end
   endtask

   initial begin
      int n, sd0;
      longint el;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset("por");
      good_map = rng(40, 70);
      #2 rst = 1'b0;
      wait_cal("w40_70", 1, 1, 40, 70, 55);

      // two windows, widest wins; a start while busy must not restart
      good_map = rng(10, 20) | rng(30, 45);
      sd0 = n_sd;
      pulse_start;
      repeat (50) @(negedge clk);
      pulse_start;
      wait_cal("two_win", 1, 1, 30, 45, 37);
      chk("start_busy_sdtaps", n_sd - sd0, 1);

      good_map = rng(5, 9) | rng(20, 24);
      pulse_start;
      wait_cal("tie", 1, 1, 5, 9, 7);

      for (int k = 0; k < 2; k++) begin
         good_map = '0;
         for (int j = 0; j < 3; j++) begin
            int s = int'($urandom_range(0, 120));
            good_map |= rng(s, s + int'($urandom_range(0, 7)));
         end
         pulse_start;
         wait_cal("random", 0, 0, 0, 0, 0);
      end

      good_map = '0;
      pulse_start;
      wait_cal("all_bad", 1, 0, 0, 0, 127);

      good_map = rng(80, 127);
      df_force = 1'b1;
      pulse_start;
      wait_cal("df_stop", 1, 1, 80, 100, 90);
      df_force = 1'b0;

      // reset mid-sweep, then relock
      good_map = rng(40, 70);
      pulse_start;
      n = 0;
      while (!(phase == 1 && phys == 90) && n < 30000) begin @(negedge clk); n++; end
      chk("reach_tap90", phys, 90);
      chk("mid_win_lo", win_lo, 40);
      #2 rst = 1'b1;
      #1 chk_reset("mid_rst");
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      wait_cal("relock", 1, 1, 40, 70, 55);

      // no frames at all: timeout in the first tap
      frames_en = 1'b0;
      @(negedge clk); #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      n = 0;
      while (!busy && n < 20) begin @(negedge clk); n++; end
      n = 0;
      while (busy && n < 5000) begin @(negedge clk); n++; end
      el = cyc - last_step;
      chk("tmo_busy", busy, 0);
      chk("tmo_cal_fail", cal_fail, 1);
      chk("tmo_locked", locked, 0);
      chk("tmo_cur_tap", cur_tap, 0);
      chk("tmo_win_lo", win_lo, 0);
      chk("tmo_win_hi", win_hi, 0);
      chk("tmo_not_early", longint'(el >= TIMEOUT), 1);
      chk("tmo_not_late", longint'(el <= TIMEOUT + SETTLE + 3), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule

// File: doc/rgmii_rx_dly_cal.md
Name: rgmii_rx_dly_cal

Overview:
- Calibration controller for the RGMII receive input-delay chain: 5 IODELAY taps (RXD[3:0] and RX_CTL) feeding IDDRs.
- Drives the shared dynamic-delay controls: SDTAP, VALUE and SETN. All five lanes move together.
- Sweeps the delay, scores each tap using the preamble of received frames, then parks the delay at the centre of the widest passing window.
- Sits between the DDR capture wrapper and the MAC receive logic. MAC ignores data until `locked`.

Parameters:
- STATIC_DLY, 63, tap value loaded by an SDTAP pulse; must match the IODELAY static setting.
- MAX_TAP, 127, highest legal tap index.
- FRAMES_PER_TAP, 4, frames scored per tap.
- PRE_SAMPLES, 6, preamble cycles checked per frame, counted from frame start.
- SETTLE, 8, idle cycles after each VALUE step or SDTAP load.
- TIMEOUT, 2^20, cycles allowed without a frame start while scoring one tap.

Ports:
- clk, in, 1, RX clock; same clock as the IDDRs.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, one-cycle pulse requesting (re)calibration.
- q_in, in, 10, IDDR outputs: [3:0] rise RXD, [4] rise CTL, [8:5] fall RXD, [9] fall CTL.
- df, in, 1, IODELAY DF flag, lane 0.
- sdtap, out, 1, pulse that loads STATIC_DLY.
- value, out, 1, one-cycle step pulse.
- setn, out, 1, step direction: 0 = increment, 1 = decrement.
- cur_tap, out, 7, tracked current tap.
- win_lo, out, 7, first passing tap of the best window.
- win_hi, out, 7, last passing tap of the best window.
- busy, out, 1, calibration in progress.
- locked, out, 1, delay parked at the window centre.
- cal_fail, out, 1, no passing tap found, or timeout.

Behaviour:
- Reset values: sdtap=0, value=0, setn=0, cur_tap=STATIC_DLY, win_lo=0, win_hi=0, busy=0, locked=0, cal_fail=0. State IDLE.
- Reset is honoured in any state, mid-sweep included. cur_tap then reflects the tap expected after the next SDTAP load.
- After reset deassertion, calibration starts automatically, exactly as for a start pulse.
- start in IDLE/DONE/FAIL: enter LOAD. start while busy is ignored.
- LOAD: sdtap=1 for 1 cycle, cur_tap<=STATIC_DLY, then SETTLE cycles.
- RWND:
  - setn=1; one value pulse per SETTLE+1 cycles; cur_tap decrements each pulse until 0.
  - value and setn change in the same cycle; setn is held stable while value is high.
- MEAS:
  - A frame start is a cycle with q_in[4]&q_in[9]=1 where the previous cycle had either CTL bit low.
  - The frame-start cycle and the next PRE_SAMPLES-1 cycles are scored.
  - A scored sample passes iff q_in==10'h2B5.
  - A mismatch, or either CTL bit low inside the scoring window, sets the tap-error flag.
  - Once FRAMES_PER_TAP frames are scored, the tap passes iff the error flag is clear.
- Scoring rules:
  - A frame start inside an active scoring window is not a new frame.
  - Frames that begin during SETTLE are not scored.
- TIMEOUT: the cycle counter resets on each frame start. On expiry go to FAIL: cal_fail=1, busy=0, delay left where it is.
- Window tracking:
  - Run start and run length are updated per tap.
  - The best run is replaced only if strictly longer, so the earliest window wins ties.
- NEXT:
  - If cur_tap==MAX_TAP, or df rises after a step, end the sweep (SEEK).
  - Otherwise step setn=0, wait SETTLE cycles, return to MEAS.
- SEEK:
  - Empty best window: go to FAIL with cal_fail=1, win_lo=win_hi=0.
  - Else target = (win_lo+win_hi)>>1, rounding down.
  - Step down with setn=1 until cur_tap==target.
- DONE: locked=1, busy=0. locked clears on start or reset.
- busy is 1 in every state except IDLE, DONE and FAIL.
- cur_tap never wraps and is saturated to 0..MAX_TAP. A step request beyond a bound is suppressed.

Test Plan:
- Reset, then a frame model that is good only at taps 40..70 (errors elsewhere) → sdtap pulse, 63 down-steps, sweep to 127, then 72 down-steps; win_lo=40, win_hi=70, cur_tap=55, locked=1.
- Passing taps 10..20 and 30..45 → window 30..45, cur_tap=37 (round down); equal-length windows 5..9 and 20..24 → 5..9 chosen, cur_tap=7.
- No frames after reset → cal_fail=1 after TIMEOUT cycles in the first MEAS; busy=0, locked=0.
- All taps erroneous → full sweep completes; cal_fail=1, win_lo=win_hi=0.
- rst asserted at tap 90 mid-sweep → all outputs at reset values immediately, same cycle; calibration restarts and relocks to the same window. start pulse while busy → no effect.
- df forced high after the step to tap 100, with taps 80..127 passing → sweep ends at 100; window 80..100, cur_tap=90.
